// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the round-robin arbiter
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Bit width needed to hold values 0..n-1, never less than 1.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// rtl/rr_arbiter_n_if.sv - request/grant bundle between bus masters and the arbiter
interface rr_arbiter_n_if
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) ();
  localparam int IDW = clog2_safe(N);

  logic [N-1:0]   req;
  logic [N-1:0]   req_en;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  modport master (
    output req, req_en,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, req_en,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit at or after ptr
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = clog2_safe(N)
) (
  input  logic [N-1:0]   ereq,
  input  logic [IDW-1:0] ptr,
  input  logic [IDW-1:0] excl_id,
  input  logic           excl_en,
  output logic [N-1:0]   winner,
  output logic [IDW-1:0] winner_id,
  output logic           found
);
  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   off;
  logic [IDW:0]   sum;

  always_comb begin
    cand = ereq;
    if (excl_en) cand[excl_id] = 1'b0;
    // Rotating a doubled copy puts index ptr at bit 0, so the lowest set bit is the winner offset.
    dbl   = {cand, cand};
    rot   = N'(dbl >> ptr);
    found = |cand;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDW + 1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDW + 1)'(N)) sum = sum - (IDW + 1)'(N);
    winner_id = found ? sum[IDW-1:0] : '0;
    winner    = found ? ({{(N - 1){1'b0}}, 1'b1} << winner_id) : '0;
  end
endmodule

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with enable mask and hold timeout
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter_n_if.slave bus
);
  localparam int IDW = clog2_safe(N);
  localparam int HW  = clog2_safe(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [N-1:0]   gnt_q, gnt_n;
  logic [IDW-1:0] id_q, id_n;
  logic           valid_q, valid_n;
  logic           to_q, to_n;

  logic [N-1:0]   ereq;
  logic           owner_req;
  logic           at_limit;
  logic           excl_en;
  logic [N-1:0]   win;
  logic [IDW-1:0] win_id;
  logic           found;
  logic [IDW-1:0] win_next;

  assign ereq      = bus.req & bus.req_en;
  assign owner_req = ereq[id_q];
  assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  // The owner is excluded from the search only when it is being forced out.
  assign excl_en   = (state == OWNED) && owner_req && at_limit;
  assign win_next  = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

  rr_pick #(.N(N)) u_pick (
    .ereq      (ereq),
    .ptr       (ptr),
    .excl_id   (id_q),
    .excl_en   (excl_en),
    .winner    (win),
    .winner_id (win_id),
    .found     (found)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt_q;
    id_n    = id_q;
    valid_n = valid_q;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = OWNED;
          gnt_n   = win;
          id_n    = win_id;
          valid_n = 1'b1;
          hold_n  = HW'(1);
          ptr_n   = win_next;
        end
      end
      OWNED: begin
        if (!owner_req || (at_limit && found)) begin
          if (found) begin
            gnt_n   = win;
            id_n    = win_id;
            valid_n = 1'b1;
            hold_n  = HW'(1);
            ptr_n   = win_next;
            to_n    = owner_req;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            id_n    = '0;
            valid_n = 1'b0;
            hold_n  = '0;
          end
        end else if (at_limit) begin
          hold_n = HW'(1);
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt_q    <= gnt_n;
      id_q     <= id_n;
      valid_q  <= valid_n;
      to_q     <= to_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - scoreboard bench for rr_arbiter_n against a behavioural model
module tb_rr_arbiter_n;
  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 4;
  localparam logic [N-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_n_if #(.N(N)) bus ();

  rr_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           valid;
    logic           to;
  } exp_t;

  exp_t exp_q[$];
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  int   checks  = 0;
  int   passes  = 0;

  function automatic int search(input logic [N-1:0] e, input int from, input int skip);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (from + i) % N;
      if (c != skip && e[c]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs and record what the grant outputs must be after the next edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] en);
    logic [N-1:0] e;
    int   w;
    bit   to;
    exp_t x;
    @(negedge clk);
    rst        = r;
    bus.req    = rq;
    bus.req_en = en;
    e  = rq & en;
    to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0 || !e[m_owner]) begin
      w = search(e, m_ptr, -1);
      m_owner = w;
      if (w >= 0) begin
        m_held = 1;
        m_ptr  = (w + 1) % N;
      end
    end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
      w = search(e, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
        to      = 1'b1;
      end
      m_held = 1;
    end else begin
      m_held++;
    end
    x.gnt = '0;
    if (m_owner >= 0) x.gnt[m_owner] = 1'b1;
    x.id    = (m_owner >= 0) ? IDW'(m_owner) : '0;
    x.valid = (m_owner >= 0);
    x.to    = to;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (bus.gnt === x.gnt && bus.gnt_id === x.id && bus.gnt_valid === x.valid && bus.timeout === x.to)
        passes++;
      else
        $display("FAIL grant t=%0t: got gnt=%b id=%0d valid=%b timeout=%b, need gnt=%b id=%0d valid=%b timeout=%b",
                 $time, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, x.gnt, x.id, x.valid, x.to);
      checks++;
      if ($onehot0(bus.gnt) && (bus.gnt_valid === (|bus.gnt)))
        passes++;
      else
        $display("FAIL onehot t=%0t: got gnt=%b valid=%b, need one-hot-or-zero gnt with valid=|gnt",
                 $time, bus.gnt, bus.gnt_valid);
    end
  end

  initial begin
    logic [N-1:0] rq;
    rst        = 1'b1;
    bus.req    = '0;
    bus.req_en = '0;

    step(1'b1, '0, ALL);
    step(1'b1, '0, ALL);
    repeat (5) step(1'b0, '0, ALL);

    // Owner drops its request for one cycle right after being granted.
    step(1'b0, ALL, ALL);
    repeat (10) begin
      rq = ALL;
      if (m_owner >= 0) rq[m_owner] = 1'b0;
      step(1'b0, rq, ALL);
    end

    step(1'b1, '0, ALL);
    repeat (14) step(1'b0, 4'b0011, ALL);

    step(1'b1, '0, ALL);
    repeat (12) step(1'b0, 4'b0100, ALL);

    step(1'b1, '0, ALL);
    repeat (3) step(1'b0, ALL, 4'b1010);
    for (int i = 0; i < 10 && m_owner != 1; i++) step(1'b0, ALL, 4'b1010);
    repeat (4) step(1'b0, ALL, 4'b1000);

    step(1'b1, '0, ALL);
    repeat (3) step(1'b0, 4'b0100, ALL);
    step(1'b1, ALL, ALL);
    repeat (3) step(1'b0, ALL, ALL);

    repeat (500) begin
      step(1'($urandom_range(0, 59) == 0), N'($urandom), N'($urandom | $urandom));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0)
      passes++;
    else
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
Parametrised round-robin bus arbiter for N requesters. It is the successor to the team's fixed 4-way locking arbiter. It grants one requester at a time and holds the grant while that requester keeps requesting. It adds a per-requester enable mask, a maximum-hold timeout that forces rotation, and encoded and valid grant outputs. It sits between the N bus masters and the shared bus mux, which uses gnt_id as the mux select.

Parameters:
N, 4, number of requesters (2..32)
IDW, $clog2(N), width of gnt_id (derived; not overridden)
MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req  in  N  request per requester, level
req_en  in  N  per-requester enable; a 0 masks the request
gnt  out  N  one-hot registered grant
gnt_id  out  IDW  binary index of the granted requester; 0 when none
gnt_valid  out  1  high when any gnt bit is high
timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Effective request: ereq = req & req_en. All arbitration uses ereq.
- Outputs are registered. If ereq is seen at edge t, the grant appears after edge t (latency 1).
- Two states: IDLE (no owner) and OWNED (exactly one gnt bit high).
- IDLE:
  - ereq==0 -> stay in IDLE.
  - ereq!=0 -> grant the first set bit searching from index ptr upward, wrapping mod N. Go to OWNED, hold_cnt=1, ptr=winner+1 mod N.
- OWNED, owner k, owner still requesting (ereq[k]=1):
  - MAX_HOLD==0, or hold_cnt<MAX_HOLD -> keep the grant; hold_cnt++ (saturating).
  - hold_cnt==MAX_HOLD -> timeout path.
    - Search from ptr (=k+1), excluding k.
    - If another requester is found: grant it, pulse timeout=1, hold_cnt=1, ptr=new+1.
    - If none is found: re-grant k, hold_cnt=1, no timeout pulse.
- OWNED, owner released (ereq[k]=0, via req drop or req_en drop):
  - Same edge re-arbitration from ptr, with no dead cycle.
  - If ereq==0 -> IDLE, gnt=0.
- Fairness: after granting k, requester k has the lowest priority. The worst-case wait is (N-1)*MAX_HOLD cycles plus N.
- gnt is one-hot or zero at all times. gnt_id and gnt_valid update in the same cycle as gnt.
- Simultaneous release and new requests: the new winner is chosen from the current-cycle ereq only.
- rst asserted mid-grant: all state clears on the next edge. ptr returns to 0.
- hold_cnt is $clog2(MAX_HOLD+1) bits wide and saturates; it never wraps.

Decomposition:
- Shared package rr_arb_pkg holds:
  - the state enum (IDLE, OWNED)
  - the function clog2_safe (returns 1 for N=1)
- One natural sub-module, rr_pick. It is purely combinational:
  - inputs: ereq, ptr, and an exclude index with an exclude-enable.
  - outputs: winner one-hot, winner index, found.
  - method: double-width rotate and priority-encode.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset then idle. rst=1 for 2 cycles, then req=0 -> gnt=0, gnt_valid=0, gnt_id=0 every cycle.
2. Basic rotation, N=4. req=4'b1111 held, each owner drops req for 1 cycle after its grant -> grants to 0,1,2,3,0 in order, with no idle cycle between owners.
3. Hold and timeout, MAX_HOLD=4. req=4'b0011 held constantly -> gnt=0001 for 4 cycles, then 0010 with timeout=1 for one cycle, then 0001 after 4 more cycles.
4. Lone owner at timeout, MAX_HOLD=4. req=4'b0100 only -> gnt stays 0100 continuously and timeout never pulses.
5. Mask. req=4'b1111, req_en=4'b1010 -> only gnt 0010 and 1000 ever occur. Clearing req_en[1] while it owns releases it on the next edge, and the grant goes to 1000.
6. Reset mid-grant. Owner 2 holds, pulse rst for 1 cycle with req=4'b1111 -> gnt=0 after the reset edge, then gnt=0001 (ptr back to 0) one cycle after rst deasserts.
